pipe_shifter: RTL and testbench

Parametrised, pipelined barrel shifter for the CPU datapath. It performs logical-left, logical-right and arithmetic-right shifts of a WIDTH-bit operand by a variable amount, spread across PIPE_DEPTH register stages. A valid/ready handshake with full backpressure lets the execute stage issue one shift per cycle, and a tag field carries the destination register ID through the pipeline.

---
 rtl/pipe_shifter_pkg.sv | 29 ++
 rtl/shift_level.sv | 30 +++
 rtl/pipe_shifter.sv | 132 +++++++++++++
 tb/tb_pipe_shifter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_shifter_pkg.sv
// rtl/pipe_shifter_pkg.sv - shared op encoding, control struct and sizing helpers for pipe_shifter
package pipe_shifter_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROR = 2'b11
  } shift_op_e;

  // Width-independent part of a stage register; the top wraps it with the
  // WIDTH/TAG_W dependent fields (shamt, data, tag).
  typedef struct packed {
    logic      valid;
    shift_op_e op;
    logic      fill;
  } stage_ctrl_t;

  // Shift-amount width for a given operand width.
  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction

  // Pipeline stage that hosts a given shift level.
  function automatic int level_stage(input int level, input int depth, input int levels);
    return (level * depth) / levels;
  endfunction

endpackage

// File: rtl/shift_level.sv
// rtl/shift_level.sv - one conditional shift-by-DIST level (rotate wiring only with PIPE_SHIFTER_ROTATE_EN)
module shift_level
  import pipe_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic             en,
  input  shift_op_e        op,
  input  logic             fill,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  // Pass through unless this level's shamt bit is set; then shift by DIST.
  always_comb begin
    data_out = data_in;
    if (en) begin
      case (op)
        SLL:     data_out = {data_in[WIDTH-DIST-1:0], {DIST{1'b0}}};
        SRA:     data_out = {{DIST{fill}}, data_in[WIDTH-1:DIST]};
`ifdef PIPE_SHIFTER_ROTATE_EN
        ROR:     data_out = {data_in[DIST-1:0], data_in[WIDTH-1:DIST]};
`endif
        default: data_out = {{DIST{1'b0}}, data_in[WIDTH-1:DIST]};
      endcase
    end
  end

endmodule

// File: rtl/pipe_shifter.sv
// rtl/pipe_shifter.sv - pipelined barrel shifter with valid/ready backpressure; op 11 rotates when PIPE_SHIFTER_ROTATE_EN is defined
module pipe_shifter
  import pipe_shifter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_W      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int SHAMT_W = shamt_w(WIDTH);

  typedef struct packed {
    stage_ctrl_t        ctrl;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   data;
    logic [TAG_W-1:0]   tag;
  } stage_reg_t;

  stage_reg_t         stage_q   [PIPE_DEPTH];
  stage_reg_t         stage_d   [PIPE_DEPTH];
  stage_reg_t         stage_in  [PIPE_DEPTH];
  stage_reg_t         stage_out [PIPE_DEPTH];
  logic [PIPE_DEPTH:0] adv;
  shift_op_e          entry_op;

  // Decode the requested op at entry; without rotate support op 11 behaves as SRL.
  always_comb begin
    entry_op = shift_op_e'(in_op);
`ifndef PIPE_SHIFTER_ROTATE_EN
    if (entry_op == ROR) begin
      entry_op = SRL;
    end
`endif
  end

  // The SRA fill bit is the operand sign captured here and carried with the entry.
  assign stage_in[0] = '{
    ctrl:  '{valid: in_valid, op: entry_op, fill: (entry_op == SRA) && in_data[WIDTH-1]},
    shamt: in_shamt,
    data:  in_data,
    tag:   in_tag
  };

  for (genvar k = 1; k < PIPE_DEPTH; k++) begin : g_stage_link
    assign stage_in[k] = stage_q[k-1];
  end

  // Level j shifts by 2^(SHAMT_W-1-j) and lives in stage level_stage(j); the
  // first level of a stage reads the stage input, the last one drives its output.
  for (genvar j = 0; j < SHAMT_W; j++) begin : g_level
    localparam int STAGE = level_stage(j, PIPE_DEPTH, SHAMT_W);
    localparam int BITNO = SHAMT_W - 1 - j;
    localparam bit FIRST = (j == 0) || (level_stage(j - 1, PIPE_DEPTH, SHAMT_W) != STAGE);
    localparam bit LAST  = (j == SHAMT_W - 1) || (level_stage(j + 1, PIPE_DEPTH, SHAMT_W) != STAGE);

    stage_reg_t       lvl_in;
    stage_reg_t       lvl_out;
    logic [WIDTH-1:0] lvl_data;

    if (FIRST) begin : g_first
      assign lvl_in = stage_in[STAGE];
    end else begin : g_chain
      assign lvl_in = g_level[j-1].lvl_out;
    end

    shift_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << BITNO)
    ) u_level (
      .en       (lvl_in.shamt[BITNO]),
      .op       (lvl_in.ctrl.op),
      .fill     (lvl_in.ctrl.fill),
      .data_in  (lvl_in.data),
      .data_out (lvl_data)
    );

    assign lvl_out = '{ctrl: lvl_in.ctrl, shamt: lvl_in.shamt, data: lvl_data, tag: lvl_in.tag};

    if (LAST) begin : g_last
      assign stage_out[STAGE] = lvl_out;
    end
  end

  // Advance chain: a stage moves when it is empty or its successor moves.
  always_comb begin
    adv             = '0;
    adv[PIPE_DEPTH] = out_ready;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      adv[k] = ~stage_q[k].ctrl.valid | adv[k+1];
    end
  end

  // Next stage contents: take the upstream result on advance, otherwise hold.
  always_comb begin
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      stage_d[k] = stage_q[k];
      if (adv[k]) begin
        stage_d[k] = stage_out[k];
      end
    end
  end

  // Stage registers; reset empties the pipe and zeroes every field.
  always_ff @(posedge clk) begin
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (reset) begin
        stage_q[k] <= '0;
      end else begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = stage_q[PIPE_DEPTH-1].ctrl.valid;
  assign out_data  = stage_q[PIPE_DEPTH-1].data;
  assign out_tag   = stage_q[PIPE_DEPTH-1].tag;

endmodule

// File: tb/tb_pipe_shifter.sv
// tb/tb_pipe_shifter.sv - vector table plus scoreboard bench for pipe_shifter
module tb_pipe_shifter;

  localparam int WIDTH      = 32;
  localparam int PIPE_DEPTH = 2;
  localparam int TAG_W      = 5;

`ifdef PIPE_SHIFTER_ROTATE_EN
  localparam logic [31:0] ROR_EXP = 32'h8000_0000;
`else
  localparam logic [31:0] ROR_EXP = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_data = 32'h0;
  logic [4:0]  in_shamt = 5'd0;
  logic [4:0]  in_tag = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  always #5 clk = ~clk;

  pipe_shifter #(
    .WIDTH      (WIDTH),
    .PIPE_DEPTH (PIPE_DEPTH),
    .TAG_W      (TAG_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } vec_t;

  exp_t sb_q[$];
  exp_t pend_exp;
  int   checks = 0;
  int   failures = 0;
  int   out_fires = 0;
  int   stalls = 0;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return $signed(d) >>> s;
`ifdef PIPE_SHIFTER_ROTATE_EN
      default: return (d >> s) | (d << (32 - int'(s)));
`else
      default: return d >> s;
`endif
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                      input logic [4:0] tag, input logic [31:0] exp);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = s;
    in_tag   = tag;
    pend_exp = '{data: exp, tag: tag};
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) stalls++;
      step();
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted tag=%0d", tag);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Scoreboard: push on accepted input, pop and compare on retired output.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      sb_q.delete();
    end else begin
      if (in_valid && in_ready) sb_q.push_back(pend_exp);
      if (out_valid && out_ready) begin
        out_fires++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=tag%0d/0x%08h required=no_output", out_tag, out_data);
        end else begin
          e = sb_q.pop_front();
          chk("sb_data", out_data, e.data);
          chk("sb_tag", 32'(out_tag), 32'(e.tag));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[12];
    logic [1:0]  op;
    logic [31:0] d;
    logic [4:0]  s;
    int          cnt;
    int          fires0;

    vecs[0]  = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};
    vecs[1]  = '{2'b00, 32'h0000_00FF, 5'd4,  32'h0000_0FF0};
    vecs[2]  = '{2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[3]  = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[4]  = '{2'b10, 32'h8000_0000, 5'd0,  32'h8000_0000};
    vecs[5]  = '{2'b11, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D};
    vecs[6]  = '{2'b11, 32'h0000_0001, 5'd1,  ROR_EXP};
    vecs[7]  = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    vecs[8]  = '{2'b10, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF};
    vecs[9]  = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[10] = '{2'b01, 32'hA5A5_A5A5, 5'd16, 32'h0000_A5A5};
    vecs[11] = '{2'b10, 32'hF000_0000, 5'd4,  32'hFF00_0000};

    // reset state
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_tag", 32'(out_tag), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    step();

    // SRA latency: result visible PIPE_DEPTH cycles after acceptance
    in_valid = 1'b1;
    in_op    = 2'b10;
    in_data  = 32'h8000_0000;
    in_shamt = 5'd8;
    in_tag   = 5'd7;
    pend_exp = '{data: 32'hFF80_0000, tag: 5'd7};
    @(negedge clk);
    chk("lat_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_valid_c1", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    chk("lat_valid_c2", 32'(out_valid), 32'd1);
    chk("lat_data", out_data, 32'hFF80_0000);
    step();

    // vector table, streamed back to back
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].op, vecs[i].data, vecs[i].shamt, 5'(i + 1), vecs[i].exp);
    end
    drain(20);

    // backpressure: tags 1, 2, 3 with the output stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 2'b00;
    in_data   = 32'd1;
    in_shamt  = 5'd1;
    in_tag    = 5'd1;
    pend_exp  = '{data: 32'h2, tag: 5'd1};
    @(negedge clk);
    chk("bp_ready_t1", 32'(in_ready), 32'd1);
    step();
    in_data  = 32'd2;
    in_shamt = 5'd2;
    in_tag   = 5'd2;
    pend_exp = '{data: 32'h8, tag: 5'd2};
    @(negedge clk);
    chk("bp_ready_t2", 32'(in_ready), 32'd1);
    step();
    in_data  = 32'd3;
    in_shamt = 5'd3;
    in_tag   = 5'd3;
    pend_exp = '{data: 32'h18, tag: 5'd3};
    @(negedge clk);
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_tag", 32'(out_tag), 32'd1);
    chk("bp_hold_data", out_data, 32'h2);
    step();
    @(negedge clk);
    chk("bp_hold_tag2", 32'(out_tag), 32'd1);
    chk("bp_hold_data2", out_data, 32'h2);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_retire", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    drain(20);

    // reset with two entries in flight
    out_ready = 1'b0;
    send(2'b00, 32'h5, 5'd1, 5'd9, 32'hA);
    send(2'b01, 32'hF0, 5'd4, 5'd10, 32'hF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_out_data", out_data, 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      cnt += int'(out_valid);
    end
    chk("rst_mid_no_stale", 32'(cnt), 32'd0);
    step();

    // random streaming against the reference model
    stalls = 0;
    fires0 = out_fires;
    for (int i = 0; i < 100; i++) begin
      op = 2'($urandom_range(0, 3));
      d  = $urandom;
      s  = 5'($urandom_range(0, 31));
      send(op, d, s, 5'(i), model(op, d, s));
    end
    chk("stream_stalls", 32'(stalls), 32'd0);
    drain(20);
    chk("stream_outputs", 32'(out_fires - fires0), 32'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
